// File: rtl/md_ctrl_e.sv
// E-stage multiply/divide sequencer: latches MD operands, counts a fixed
// latency, then commits the product or quotient/remainder into HI/LO.
module md_ctrl_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDop,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDresult
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  md_op_e             op_q;
  logic [31:0]        a_q, b_q;
  logic [31:0]        hi_q, lo_q;
  logic               launch, commit, mt_hi, mt_lo;
  md_op_e             op_in;

  assign op_in = md_op_e'(MDop);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    launch   = 1'b0;
    commit   = 1'b0;
    mt_hi    = 1'b0;
    mt_lo    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !req) begin
          case (op_in)
            OP_MULT, OP_MULTU: begin
              launch   = 1'b1;
              cnt_nx   = CNT_W'(MULT_CYCLES);
              state_nx = RUN;
            end
            OP_DIV, OP_DIVU: begin
              launch   = 1'b1;
              cnt_nx   = CNT_W'(DIV_CYCLES);
              state_nx = RUN;
            end
            OP_MTHI: mt_hi = 1'b1;
            OP_MTLO: mt_lo = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result datapath works only from the operands captured at launch.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               is_sdiv, a_neg, b_neg;
  logic        [31:0] div_n, div_d, div_d_safe, quo_mag, rem_mag, quo, rem;

  assign prod_s     = $signed(a_q) * $signed(b_q);
  assign prod_u     = {32'b0, a_q} * {32'b0, b_q};

  // Signed divide is done on magnitudes; 0x80000000 has magnitude 2^31 as an
  // unsigned value, which makes the overflow case fall out naturally.
  assign is_sdiv    = (op_q == OP_DIV);
  assign a_neg      = is_sdiv & a_q[31];
  assign b_neg      = is_sdiv & b_q[31];
  assign div_n      = a_neg ? (~a_q + 32'd1) : a_q;
  assign div_d      = b_neg ? (~b_q + 32'd1) : b_q;
  assign div_d_safe = (div_d == 32'd0) ? 32'd1 : div_d;
  assign quo_mag    = div_n / div_d_safe;
  assign rem_mag    = div_n % div_d_safe;
  assign quo        = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem        = a_neg ? (~rem_mag + 32'd1) : rem_mag;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: the operand latches are reset along with HI/LO so an aborted
  // operation leaves no stale state behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= OP_NONE;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (launch) begin
        op_q <= op_in;
        a_q  <= SrcA;
        b_q  <= SrcB;
      end
      if (mt_hi) hi_q <= SrcA;
      if (mt_lo) lo_q <= SrcA;
      if (commit) begin
        case (op_q)
          OP_MULT: begin
            hi_q <= prod_s[63:32];
            lo_q <= prod_s[31:0];
          end
          OP_MULTU: begin
            hi_q <= prod_u[63:32];
            lo_q <= prod_u[31:0];
          end
          OP_DIV, OP_DIVU: begin
            // Divide by zero burns the full latency but leaves HI/LO alone.
            if (b_q != 32'd0) begin
              hi_q <= rem;
              lo_q <= quo;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy     = (state == RUN);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign MDresult = hi_q;

endmodule

// File: tb/tb_md_ctrl_e.sv
// Bench for md_ctrl_e: directed test-plan scenarios plus random traffic,
// all checked each cycle against a behavioural HI/LO/busy model.
module tb_md_ctrl_e;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  MDop = 3'd0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        busy;
  logic [31:0] HI, LO, MDresult;

  always #5 clk = ~clk;

  md_ctrl_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .MDop(MDop),
    .SrcA(SrcA), .SrcB(SrcB), .req(req), .busy(busy),
    .HI(HI), .LO(LO), .MDresult(MDresult)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted op schedules its final HI/LO for a fixed
  // number of edges later; MTHI/MTLO write immediately.
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_valid = 1'b0;

  task automatic model_accept();
    longint sa, sb, sq, sr, sp;
    logic [63:0] up;
    sa = longint'($signed(SrcA));
    sb = longint'($signed(SrcB));
    case (MDop)
      3'd1: begin
        sp = sa * sb;
        {p_hi, p_lo} = sp;
        p_valid = 1'b1; m_busy = 1'b1; m_cnt = MC;
      end
      3'd2: begin
        up = {32'b0, SrcA} * {32'b0, SrcB};
        {p_hi, p_lo} = up;
        p_valid = 1'b1; m_busy = 1'b1; m_cnt = MC;
      end
      3'd3: begin
        p_valid = (SrcB != 0);
        if (p_valid) begin
          sq = sa / sb;
          sr = sa % sb;
          p_lo = sq[31:0];
          p_hi = sr[31:0];
        end
        m_busy = 1'b1; m_cnt = DC;
      end
      3'd4: begin
        p_valid = (SrcB != 0);
        if (p_valid) begin
          p_lo = SrcA / SrcB;
          p_hi = SrcA % SrcB;
        end
        m_busy = 1'b1; m_cnt = DC;
      end
      3'd5: m_hi = SrcA;
      3'd6: m_lo = SrcA;
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0; m_cnt = 0; m_hi = '0; m_lo = '0; p_valid = 1'b0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        if (p_valid) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end
    end else if (start && !req) begin
      model_accept();
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
      check("mdresult", MDresult, m_hi);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r);
    @(negedge clk);
    start = 1'b1; MDop = op; SrcA = a; SrcB = b; req = r;
    @(negedge clk);
    start = 1'b0; MDop = 3'd0; req = 1'b0;
  endtask

  task automatic wait_idle(input bit scramble, output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (scramble) begin
        SrcA = $urandom;
        SrcB = $urandom;
      end
      @(negedge clk);
    end
    if (busy) check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int n;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b1;

    // MULT -2 * 3
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_idle(1'b0, n);
    check("mult_cycles", 32'(n), 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // MULTU with operands scrambled while running
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle(1'b1, n);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    // DIV -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(1'b0, n);
    check("div_cycles", 32'(n), 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // MTHI, then DIVU by zero
    issue(3'd5, 32'h1234_5678, 32'd0, 1'b0);
    wait_idle(1'b0, n);
    check("mthi_nobusy", 32'(n), 32'd0);
    issue(3'd4, 32'd100, 32'd0, 1'b0);
    wait_idle(1'b0, n);
    check("divz_cycles", 32'(n), 32'd10);
    check("divz_hi", HI, 32'h1234_5678);
    check("divz_lo", LO, 32'hFFFF_FFFD);

    // Signed overflow divide
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(1'b0, n);
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'h0000_0000);

    // MTLO and DIV during busy are dropped
    issue(3'd1, 32'd7, 32'd6, 1'b0);
    start = 1'b1; MDop = 3'd6; SrcA = 32'hDEAD_BEEF;
    @(negedge clk);
    MDop = 3'd3; SrcA = 32'd50; SrcB = 32'd5;
    @(negedge clk);
    start = 1'b0; MDop = 3'd0;
    wait_idle(1'b0, n);
    check("busy_ign_hi", HI, 32'd0);
    check("busy_ign_lo", LO, 32'd42);
    @(negedge clk);
    check("no_late_start", {31'b0, busy}, 32'd0);

    // req blocks a MULT start
    issue(3'd1, 32'd5, 32'd5, 1'b1);
    check("req_busy", {31'b0, busy}, 32'd0);
    check("req_hi", HI, 32'd0);
    check("req_lo", LO, 32'd42);

    // Reset mid-DIV aborts
    issue(3'd3, 32'd1000, 32'd7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_nocommit_busy", {31'b0, busy}, 32'd0);
    check("abort_nocommit_hi", HI, 32'd0);
    check("abort_nocommit_lo", LO, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) != 0);
      MDop  = 3'($urandom_range(0, 7));
      req   = ($urandom_range(0, 7) == 0);
      SrcA  = pick();
      SrcB  = pick();
      if (i % 200 == 199) begin
        #2 reset = 1'b0;
        #2 reset = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0; req = 1'b0; MDop = 3'd0;
    wait_idle(1'b0, n);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md_ctrl_e.md
Name: md_ctrl_E

Overview:
Multi-cycle multiply/divide sequencer for the E stage. It sits beside alu_E, accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E-stage decode, and latches the operands. It counts a fixed latency and then commits the result to the HI/LO registers. It drives a busy flag that the hazard unit combines with start to stall MFHI/MFLO and further MD instructions.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (must be >=1).
DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (must be >=1).
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  E-stage MD instruction valid this cycle.
MDop  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
SrcA  input  32  rs operand / dividend / MTHI-MTLO source.
SrcB  input  32  rt operand / divisor.
req  input  1  exception/interrupt commit in M stage; blocks a start in the same cycle.
busy  output  1  operation in flight.
HI  output  32  HI register.
LO  output  32  LO register.
MDresult  output  32  reserved for MFHI/MFLO muxing outside this block; this block drives HI.

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, counter=0, latched op and operands cleared. Reset mid-operation aborts the operation and does not commit a result.
- State machine:
  - IDLE (busy=0) -> RUN (busy=1).
  - Transition on a rising edge with start=1, req=0, busy=0 and MDop in 1..4.
  - On that edge E0: latch MDop, SrcA and SrcB; load counter with MULT_CYCLES or DIV_CYCLES.
- RUN:
  - Each rising edge decrements the counter.
  - On the edge where the counter equals 1: commit HI/LO from the latched operands, clear busy and return to IDLE.
  - busy is high for exactly N cycles after E0. New HI/LO are visible after edge E0+N.
- Start filtering:
  - start while busy=1 is ignored (the hazard unit must stall). No queueing.
  - start with MDop 0 or 7 is ignored.
  - start with req=1 is ignored for every MDop.
- MTHI/MTLO:
  - Accepted only when busy=0 and req=0.
  - Write SrcA into HI or LO at E0. busy is not asserted; the other register is unchanged.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient to LO, unsigned remainder to HI.
  - Divisor = 0 (DIV or DIVU): the block still runs DIV_CYCLES with busy high, then leaves HI/LO unchanged.
- Operands come only from the values latched at E0. Changes on SrcA/SrcB during RUN have no effect.
- Commit and a new start on the same edge cannot occur: busy is still 1 on the commit edge, so the start is ignored. A new op is accepted on the edge after busy falls.
- HI and LO are registered outputs. No combinational path from SrcA/SrcB to HI/LO.

Test Plan:
1. Reset, then MULT with SrcA=0xFFFFFFFE (-2), SrcB=3 -> busy=1 for 5 cycles; after E0+5, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. MULTU with SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001. Changing SrcA/SrcB during RUN does not change the result.
3. DIV with SrcA=0xFFFFFFF9 (-7), SrcB=2 -> busy for 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
4. MTHI 0x12345678, then DIVU 100/0 -> HI=0x12345678 and LO unchanged after 10 busy cycles. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
5. MULT started, then MTLO and DIV asserted with start during busy -> both ignored; the MULT result commits. start=1 with req=1 for MULT -> busy stays 0 and HI/LO are unchanged.
6. Pull reset low on the 3rd cycle of a DIV -> busy, HI and LO go to 0 immediately. With reset=1 and no new start, no commit occurs.
